// File: rtl/level_pkg.sv
// level_pkg: state encoding, scene constants and exit mapping for level_sequencer
package level_pkg;
  typedef enum logic [2:0] {IDLE, FADE_OUT, FADE_IN, PLAY, WIN} state_t;
  localparam logic [1:0] SCENE_TITLE = 2'd0;
  localparam logic [3:0] FADE_MAX = 4'hF;
  function automatic logic [1:0] scene_win(input int num_levels);
    return 2'(num_levels + 1);
  endfunction
  function automatic state_t exit_state(input logic [1:0] target, input logic [1:0] win);
    return target == SCENE_TITLE ? IDLE : target == win ? WIN : PLAY;
  endfunction
endpackage

// File: rtl/vblnk_edge.sv
// vblnk_edge: registered rising-edge detect of vblnk, one frame_tick per frame
module vblnk_edge (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic frame_tick
);
  logic vblnk_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_d <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vblnk_d <= vblnk;
      frame_tick <= vblnk & ~vblnk_d;
    end
  end
endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: scene select with frame-synced fade transitions; brightness ramps only with LEVEL_SEQ_FADE_EN
module level_sequencer
  import level_pkg::*;
#(
  parameter int NUM_LEVELS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       start,
  input  logic       level_done,
  input  logic       restart,
  output logic [1:0] level_sel,
  output logic [3:0] fade,
  output logic       scene_active,
  output logic       frame_tick
);
`ifdef LEVEL_SEQ_FADE_EN
  localparam bit FADE_EN = 1'b1;
`else
  localparam bit FADE_EN = 1'b0;
`endif
  localparam logic [1:0] WIN_SCENE = scene_win(NUM_LEVELS);
  state_t state, state_n;
  logic [1:0] target, target_n, level_sel_n;
  logic [3:0] fade_n;
  vblnk_edge u_edge (
    .clk(clk),
    .rst(rst),
    .vblnk(vblnk),
    .frame_tick(frame_tick)
  );
  // with fading disabled fade stays at FADE_MAX, so both ramps collapse to a single tick
  always_comb begin
    state_n = state;
    target_n = target;
    level_sel_n = level_sel;
    fade_n = fade;
    case (state)
      IDLE: begin
        level_sel_n = SCENE_TITLE;
        fade_n = FADE_MAX;
        if (start) begin
          target_n = 2'd1;
          state_n = FADE_OUT;
        end
      end
      FADE_OUT: begin
        if (restart) target_n = SCENE_TITLE;
        if (frame_tick) begin
          if (FADE_EN && fade != 4'd0) fade_n = fade - 4'd1;
          else begin
            level_sel_n = target_n;
            state_n = FADE_IN;
          end
        end
      end
      FADE_IN: begin
        if (restart) begin
          target_n = SCENE_TITLE;
          state_n = FADE_OUT;
        end else if (frame_tick) begin
          fade_n = (FADE_EN && fade != FADE_MAX) ? fade + 4'd1 : fade;
          if (fade_n == FADE_MAX) state_n = exit_state(target, WIN_SCENE);
        end
      end
      PLAY: begin
        if (restart) begin
          target_n = SCENE_TITLE;
          state_n = FADE_OUT;
        end else if (level_done) begin
          target_n = level_sel + 2'd1;
          state_n = FADE_OUT;
        end
      end
      WIN: begin
        level_sel_n = WIN_SCENE;
        if (start || restart) begin
          target_n = SCENE_TITLE;
          state_n = FADE_OUT;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      target <= SCENE_TITLE;
      level_sel <= SCENE_TITLE;
      fade <= FADE_MAX;
      scene_active <= 1'b0;
    end else begin
      state <= state_n;
      target <= target_n;
      level_sel <= level_sel_n;
      fade <= fade_n;
      scene_active <= state_n == PLAY;
    end
  end
endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: directed checks of scene sequencing, fades, restart priority and reset
module tb_level_sequencer;
`ifdef LEVEL_SEQ_FADE_EN
  localparam bit FADE = 1'b1;
`else
  localparam bit FADE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, vblnk = 1'b0, start = 1'b0, level_done = 1'b0, restart = 1'b0;
  logic [1:0] level_sel;
  logic [3:0] fade;
  logic scene_active, frame_tick;
  int n_assert = 0, n_fail = 0, tick_cnt = 0, run = 0, max_run = 0, t0 = 0;
  logic [1:0] prev_sel = 2'd0;
  logic prev_tick = 1'b0, prev_rst = 1'b1;

  level_sequencer #(.NUM_LEVELS(2)) dut (
    .clk(clk),
    .rst(rst),
    .vblnk(vblnk),
    .start(start),
    .level_done(level_done),
    .restart(restart),
    .level_sel(level_sel),
    .fade(fade),
    .scene_active(scene_active),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // tick counting, pulse width and scene-change-only-after-tick watch
  always @(negedge clk) begin
    if (frame_tick) tick_cnt++;
    run = frame_tick ? run + 1 : 0;
    if (run > max_run) max_run = run;
    if (!rst && !prev_rst && level_sel !== prev_sel) begin
      n_assert++;
      assert (prev_tick === 1'b1) else begin
        n_fail++;
        $error("FAIL sel_change_off_tick observed=%0d expected=%0d", prev_tick, 1);
      end
    end
    prev_sel = level_sel;
    prev_tick = frame_tick;
    prev_rst = rst;
  end

  task automatic frame();
    @(negedge clk) vblnk = 1'b1;
    repeat (2) @(negedge clk);
    vblnk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic ld, input logic rs);
    @(negedge clk);
    start = s;
    level_done = ld;
    restart = rs;
    @(negedge clk);
    start = 1'b0;
    level_done = 1'b0;
    restart = 1'b0;
  endtask

  task automatic trans(input logic [1:0] from, input logic [1:0] to, input logic sa_end, input int f0, input bit noise);
    int n_out, n_in;
    n_out = FADE ? f0 : 0;
    n_in = FADE ? 15 : 1;
    for (int k = 1; k <= n_out; k++) begin
      frame();
      chk("out_fade", 32'(fade), 32'(f0 - k));
      chk("out_sel", 32'(level_sel), 32'(from));
    end
    frame();
    chk("swap_sel", 32'(level_sel), 32'(to));
    chk("swap_fade", 32'(fade), FADE ? 32'd0 : 32'd15);
    if (noise) pulse(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= n_in; k++) begin
      frame();
      chk("in_fade", 32'(fade), FADE ? 32'(k) : 32'd15);
      chk("in_sa", 32'(scene_active), (k == n_in) ? 32'(sa_end) : 32'd0);
      chk("in_sel", 32'(level_sel), 32'(to));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_sel", 32'(level_sel), 0);
    chk("rst_fade", 32'(fade), 15);
    chk("rst_sa", 32'(scene_active), 0);
    chk("rst_tick", 32'(frame_tick), 0);
    t0 = tick_cnt;
    repeat (5) frame();
    chk("idle_ticks", 32'(tick_cnt - t0), 5);
    chk("idle_sel", 32'(level_sel), 0);
    chk("idle_fade", 32'(fade), 15);
    chk("idle_sa", 32'(scene_active), 0);
    t0 = tick_cnt;
    @(negedge clk) vblnk = 1'b1;
    repeat (100) @(negedge clk);
    vblnk = 1'b0;
    repeat (3) @(negedge clk);
    chk("long_vblnk_ticks", 32'(tick_cnt - t0), 1);
    chk("tick_width", 32'(max_run), 1);
    // title -> level 1 -> level 2 -> win -> title
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    trans(2'd0, 2'd1, 1'b1, 15, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("sa_drop", 32'(scene_active), 0);
    trans(2'd1, 2'd2, 1'b1, 15, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    trans(2'd2, 2'd3, 1'b0, 15, 1'b0);
    repeat (2) frame();
    chk("win_sel", 32'(level_sel), 3);
    chk("win_sa", 32'(scene_active), 0);
    pulse(1'b1, 1'b0, 1'b0);
    trans(2'd3, 2'd0, 1'b0, 15, 1'b0);
    frame();
    chk("idle_again_sel", 32'(level_sel), 0);
    // restart during the level 2 fade-in at fade 7
    pulse(1'b1, 1'b0, 1'b0);
    trans(2'd0, 2'd1, 1'b1, 15, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    frame();
    chk("play_start_sel", 32'(level_sel), 1);
    chk("play_start_sa", 32'(scene_active), 1);
    pulse(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < (FADE ? 15 : 0); k++) frame();
    frame();
    chk("l2_swap_sel", 32'(level_sel), 2);
    for (int k = 0; k < (FADE ? 7 : 0); k++) frame();
    chk("pre_restart_fade", 32'(fade), FADE ? 32'd7 : 32'd15);
    pulse(1'b0, 1'b0, 1'b1);
    chk("restart_fade_hold", 32'(fade), FADE ? 32'd7 : 32'd15);
    chk("restart_sa", 32'(scene_active), 0);
    trans(2'd2, 2'd0, 1'b0, 7, 1'b0);
    // restart beats level_done
    pulse(1'b1, 1'b0, 1'b0);
    trans(2'd0, 2'd1, 1'b1, 15, 1'b0);
    pulse(1'b0, 1'b1, 1'b1);
    trans(2'd1, 2'd0, 1'b0, 15, 1'b0);
    // reset in the middle of a fade-out
    pulse(1'b1, 1'b0, 1'b0);
    trans(2'd0, 2'd1, 1'b1, 15, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < (FADE ? 3 : 0); k++) frame();
    chk("mid_fade", 32'(fade), FADE ? 32'd12 : 32'd15);
    chk("mid_sel", 32'(level_sel), 1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("abort_sel", 32'(level_sel), 0);
    chk("abort_fade", 32'(fade), 15);
    chk("abort_sa", 32'(scene_active), 0);
    chk("abort_tick", 32'(frame_tick), 0);
    repeat (2) frame();
    chk("post_abort_sel", 32'(level_sel), 0);
    chk("post_abort_fade", 32'(fade), 15);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
- Scene/level controller for the VGA draw chain. Decides which scene renderer (title, level 1, level 2, win screen) drives the frame, and sequences frame-synchronous fade-out/fade-in transitions between scenes.
- Outputs a scene select for the renderer mux and a 4-bit brightness for the downstream RGB scaler.
- Sits beside the vga timing generator, upstream of the level render modules.

Parameters:
- NUM_LEVELS, 2, number of playable levels. Scenes: 0 = title, 1..NUM_LEVELS = levels, NUM_LEVELS+1 = win. Legal range 1..2 (scene fits 2 bits).

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset
- vblnk  in  1  vertical blanking from timing generator
- start  in  1  single-cycle pulse, start game / leave win screen
- level_done  in  1  single-cycle pulse from game logic, player finished current level
- restart  in  1  single-cycle pulse, return to title
- level_sel  out  2  current scene index
- fade  out  4  brightness, 15 = full, 0 = black
- scene_active  out  1  high only in PLAY (game logic enabled)
- frame_tick  out  1  one-cycle pulse per frame

Interface:
- Reset rst is synchronous, active-high.
- Clock is clk.

Behaviour:
- All outputs and state are registered.
- Reset values: state IDLE, level_sel 0, fade 15, scene_active 0, frame_tick 0, target 0, vblnk_d 0. Reset mid-transition aborts immediately to these values.

frame_tick:
- Registered rising edge of vblnk: frame_tick = vblnk & ~vblnk_d, asserted one cycle after vblnk rises.
- Exactly one pulse per frame regardless of vblnk width.

States and transitions:
- IDLE: level_sel 0, fade 15. start → target 1, go to FADE_OUT. level_done and restart are ignored.
- FADE_OUT: evaluated on frame_tick only.
  - fade > 0 → fade decrements by 1.
  - fade == 0 → level_sel ← target, go to FADE_IN.
- FADE_IN: evaluated on frame_tick only.
  - fade increments by 1.
  - On the tick where fade becomes 15, go to target-dependent state: PLAY for 1..NUM_LEVELS, IDLE for 0, WIN for NUM_LEVELS+1.
- PLAY: scene_active = 1. level_done → target level_sel+1, go to FADE_OUT.
- WIN: level_sel NUM_LEVELS+1. start or restart → target 0, go to FADE_OUT.

Timing and gating:
- scene_active is registered; it is high exactly in PLAY and drops on the cycle FADE_OUT is entered.
- A full transition from fade 15 takes 31 frame ticks: 16 ticks out (15 decrements, then the swap), 15 ticks in.
- level_sel changes only on a frame_tick, i.e. during vertical blanking, so there is never a mid-frame scene switch.
- start outside IDLE/WIN is ignored. level_done outside PLAY is ignored (not latched).

restart:
- In FADE_IN, PLAY or WIN: target ← 0, go to FADE_OUT, continuing from the current fade value (no jump).
- In FADE_OUT: only overrides target to 0.
- In IDLE: ignored.
- restart and level_done in the same cycle: restart wins.
- restart and frame_tick in the same cycle during FADE_IN: restart wins; fade is not incremented that cycle.

Arithmetic:
- fade is unsigned 4-bit and saturates; it never wraps below 0 or above 15.
- level_sel+1 is computed in 2 bits; it is bounded by the NUM_LEVELS constraint, so no overflow.

Optional Feature:
- Macro: LEVEL_SEQ_FADE_EN.
- Defined: fade ramps exactly as specified above.
- Undefined:
  - fade is constant 15.
  - FADE_OUT swaps level_sel on the first frame_tick.
  - FADE_IN exits on the next frame_tick.
  - A transition therefore takes 2 frame ticks; restart and priority rules are unchanged.

Decomposition:
- New package level_pkg holds:
  - State enum: IDLE, FADE_OUT, FADE_IN, PLAY, WIN.
  - Constants: SCENE_TITLE = 0, FADE_MAX = 4'hF, SCENE_WIN function of NUM_LEVELS.
- Sub-module vblnk_edge (vblnk register + rising-edge pulse) produces frame_tick.
- The FSM and fade counter stay in level_sequencer.

Test Plan:
- rst 2 cycles, then 5 frames of vblnk with no inputs → level_sel 0, fade 15, scene_active 0 throughout; frame_tick pulses 5 times, each 1 cycle. vblnk held high 100 cycles → exactly 1 tick.
- start in IDLE → fade steps 15→0 over 15 ticks; on 16th tick level_sel = 1; fade 0→15 over ticks 17-31; scene_active = 1 on tick 31. level_sel is stable except on tick cycles.
- PLAY level 1, level_done → level_sel 2 after 16 ticks, PLAY after 31. Second level_done → level_sel 3, WIN, scene_active 0. start → back to IDLE with level_sel 0.
- FADE_IN of level 2 at fade 7, restart → FADE_OUT: fade 6..0 over next 7 ticks; swap to level_sel 0 on the 8th tick; fade ramps to 15, ending in IDLE.
- PLAY level 1, restart and level_done in same cycle → final scene 0, not 2. start during PLAY and level_done during FADE_IN → no effect.
- Build without LEVEL_SEQ_FADE_EN: start → level_sel 1 on tick 1, PLAY on tick 2, fade 15 always. rst asserted mid-FADE_OUT (either build) → all outputs at reset values the following cycle.
